// File: rtl/bpsk_seq_pkg.sv
// Shared types and width helpers for the BPSK symbol sequencer.
package bpsk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_GUARD
  } state_e;

  localparam int BYTE_W = 8;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bpsk_symbol_timer.sv
// Modulo-SYMBOL_CYCLES symbol timer with registered first-cycle strobe.
module bpsk_symbol_timer
  import bpsk_seq_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic strobe_o,
  output logic boundary_o
);

  localparam int CW = cnt_w(SYMBOL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SYMBOL_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          run_q;
  logic          strobe_q;

  // run_i says the sequencer is active in the coming cycle; a fresh run starts at 0.
  always_comb begin
    count_d = '0;
    if (run_i && run_q && (count_q != LAST)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      run_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      run_q    <= run_i;
      strobe_q <= run_i && (count_d == '0);
    end
  end

  assign strobe_o   = strobe_q;
  assign boundary_o = run_q && (count_q == LAST);

endmodule

// File: rtl/bpsk_symbol_sequencer.sv
// Byte-to-BPSK symbol sequencer driving NCO clk_en/pi: preamble, data, guard, idle.
module bpsk_symbol_sequencer
  import bpsk_seq_pkg::*;
#(
  parameter int                      SYMBOL_CYCLES    = 64,
  parameter int                      PREAMBLE_LEN     = 8,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_PATTERN = 8'b10101010,
  parameter int                      GUARD_SYMBOLS    = 4,
  parameter bit                      DIFFERENTIAL     = 1'b0
) (
  input  logic              pll_clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              clk_en,
  output logic              pi,
  output logic              symbol_strobe,
  output logic              busy
);

  localparam int PW = cnt_w(PREAMBLE_LEN);
  localparam int GW = cnt_w(GUARD_SYMBOLS);
  localparam logic [PW-1:0] P_LAST = PW'(PREAMBLE_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_SYMBOLS - 1);

  state_e                  state_q;
  logic [BYTE_W-1:0]       hold_q, shift_q;
  logic                    hold_full_q, hold_full_d;
  logic                    byte_ready_q;
  logic [2:0]              bit_q;
  logic [PW-1:0]           pre_cnt_q;
  logic [PREAMBLE_LEN-1:0] pre_sh_q;
  logic [GW-1:0]           guard_cnt_q;
  logic                    pi_q, clk_en_q, busy_q;

  logic boundary, transfer, move, guard_done, run_d;

  function automatic logic data_pi(input logic prev, input logic b);
    return DIFFERENTIAL ? (prev ^ b) : b;
  endfunction

  assign transfer    = byte_valid && byte_ready_q;
  assign move        = hold_full_q &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_DATA) && boundary && (bit_q == 3'd7)));
  assign hold_full_d = transfer || (hold_full_q && !move);
  assign guard_done  = (state_q == ST_GUARD) && boundary && (guard_cnt_q == G_LAST);
  assign run_d       = (state_q == ST_IDLE) ? hold_full_q : !guard_done;

  bpsk_symbol_timer #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES)
  ) u_timer (
    .clk_i     (pll_clock),
    .rst_ni    (reset_n),
    .run_i     (run_d),
    .strobe_o  (symbol_strobe),
    .boundary_o(boundary)
  );

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      hold_full_q  <= 1'b0;
      byte_ready_q <= 1'b1;
      bit_q        <= '0;
      pre_cnt_q    <= '0;
      pre_sh_q     <= '0;
      guard_cnt_q  <= '0;
      pi_q         <= 1'b0;
      clk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      hold_full_q  <= hold_full_d;
      byte_ready_q <= !hold_full_d;
      if (transfer) hold_q <= byte_data;

      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            state_q   <= ST_PREAMBLE;
            shift_q   <= hold_q;
            pre_cnt_q <= '0;
            pre_sh_q  <= PREAMBLE_PATTERN << 1;
            pi_q      <= PREAMBLE_PATTERN[PREAMBLE_LEN-1];
            clk_en_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (boundary) begin
            if (pre_cnt_q == P_LAST) begin
              state_q <= ST_DATA;
              bit_q   <= '0;
              pi_q    <= data_pi(pi_q, shift_q[BYTE_W-1]);
            end else begin
              pre_cnt_q <= pre_cnt_q + 1'b1;
              pre_sh_q  <= pre_sh_q << 1;
              pi_q      <= pre_sh_q[PREAMBLE_LEN-1];
            end
          end
        end
        ST_DATA: begin
          if (boundary) begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              // A waiting byte continues the burst with no gap.
              if (hold_full_q) begin
                shift_q <= hold_q;
                pi_q    <= data_pi(pi_q, hold_q[BYTE_W-1]);
              end else begin
                state_q     <= ST_GUARD;
                guard_cnt_q <= '0;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q << 1;
              pi_q    <= data_pi(pi_q, shift_q[BYTE_W-2]);
            end
          end
        end
        ST_GUARD: begin
          if (boundary) begin
            if (guard_cnt_q == G_LAST) begin
              state_q  <= ST_IDLE;
              pi_q     <= 1'b0;
              clk_en_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              guard_cnt_q <= guard_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign clk_en     = clk_en_q;
  assign pi         = pi_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bpsk_symbol_sequencer.sv
// Scoreboard bench: three sequencer instances (plain, differential, one-cycle symbols).
module tb_bpsk_symbol_sequencer;

  localparam int PL = 4;
  localparam int GS = 2;
  localparam logic [3:0] PAT = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n = 3'b111;
  logic [2:0] valid = 3'b000;
  logic [7:0] data [3];
  logic [2:0] ready, clk_en, pi, strobe, busy;

  int checks = 0;
  int errors = 0;

  bit         exp_q [3][$];
  int         len_q [3][$];
  bit         abort [3];
  logic [7:0] bq[$];

  function automatic int sc_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit diff_of(input int i);
    return (i == 1);
  endfunction

  bpsk_symbol_sequencer #(.SYMBOL_CYCLES(4), .PREAMBLE_LEN(PL), .PREAMBLE_PATTERN(PAT),
                          .GUARD_SYMBOLS(GS), .DIFFERENTIAL(1'b0)) u_dut0 (
    .pll_clock(clk), .reset_n(rst_n[0]), .byte_data(data[0]), .byte_valid(valid[0]),
    .byte_ready(ready[0]), .clk_en(clk_en[0]), .pi(pi[0]), .symbol_strobe(strobe[0]),
    .busy(busy[0]));

  bpsk_symbol_sequencer #(.SYMBOL_CYCLES(4), .PREAMBLE_LEN(PL), .PREAMBLE_PATTERN(PAT),
                          .GUARD_SYMBOLS(GS), .DIFFERENTIAL(1'b1)) u_dut1 (
    .pll_clock(clk), .reset_n(rst_n[1]), .byte_data(data[1]), .byte_valid(valid[1]),
    .byte_ready(ready[1]), .clk_en(clk_en[1]), .pi(pi[1]), .symbol_strobe(strobe[1]),
    .busy(busy[1]));

  bpsk_symbol_sequencer #(.SYMBOL_CYCLES(1), .PREAMBLE_LEN(PL), .PREAMBLE_PATTERN(PAT),
                          .GUARD_SYMBOLS(GS), .DIFFERENTIAL(1'b0)) u_dut2 (
    .pll_clock(clk), .reset_n(rst_n[2]), .byte_data(data[2]), .byte_valid(valid[2]),
    .byte_ready(ready[2]), .clk_en(clk_en[2]), .pi(pi[2]), .symbol_strobe(strobe[2]),
    .busy(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole burst as a list of per-symbol pi values.
  task automatic push_burst(input int i);
    logic [3:0] pat;
    logic [7:0] b;
    bit prev, d;
    pat  = PAT;
    prev = 1'b0;
    for (int k = PL - 1; k >= 0; k--) begin
      prev = pat[k[1:0]];
      exp_q[i].push_back(prev);
    end
    foreach (bq[j]) begin
      b = bq[j];
      for (int k = 7; k >= 0; k--) begin
        d    = b[k[2:0]];
        prev = diff_of(i) ? (prev ^ d) : d;
        exp_q[i].push_back(prev);
      end
    end
    repeat (GS) exp_q[i].push_back(prev);
    len_q[i].push_back((PL + 8 * bq.size() + GS) * sc_of(i));
  endtask

  // Monitor: per-cycle output checks and symbol scoreboard.
  int cyc   [3];
  bit bprev [3];
  bit cur   [3];
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy[i]) begin
        if (!bprev[i]) cyc[i] = 0;
        check($sformatf("strobe_phase%0d", i), strobe[i], ((cyc[i] % sc_of(i)) == 0));
        check($sformatf("clk_en%0d", i), clk_en[i], 1);
        if (strobe[i]) begin
          check($sformatf("sym_avail%0d", i), (exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) cur[i] = exp_q[i].pop_front();
        end
        check($sformatf("pi%0d", i), pi[i], cur[i]);
        cyc[i]++;
      end else begin
        check($sformatf("idle_outputs%0d", i), {clk_en[i], pi[i], strobe[i]}, 0);
        if (bprev[i]) begin
          if (abort[i]) abort[i] = 1'b0;
          else begin
            check($sformatf("len_avail%0d", i), (len_q[i].size() > 0), 1);
            if (len_q[i].size() > 0) check($sformatf("burst_len%0d", i), cyc[i], len_q[i].pop_front());
          end
        end
      end
      bprev[i] = busy[i];
    end
  end

  task automatic send(input int i, input logic [7:0] b, input bit last);
    int n;
    @(negedge clk);
    data[i]  = b;
    valid[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready[i], 1);
    @(posedge clk);
    #1;
    check("ready_after_xfer", ready[i], 0);
    if (last) valid[i] = 1'b0;
  endtask

  task automatic first_checks(input int i);
    logic [3:0] pat;
    pat = PAT;
    @(posedge clk);
    #1;
    check("start_busy", busy[i], 1);
    check("start_clk_en", clk_en[i], 1);
    check("start_strobe", strobe[i], 1);
    check("start_pi", pi[i], pat[3]);
    check("start_ready", ready[i], 1);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("burst_end", busy[i], 0);
  endtask

  task automatic run_burst(input int i);
    push_burst(i);
    foreach (bq[k]) begin
      send(i, bq[k], (k == bq.size() - 1));
      if (k == 0) first_checks(i);
    end
    wait_idle(i);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int hits, lo, n;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    #2 rst_n = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", ready[i], 1);
      check("reset_outputs", {busy[i], clk_en[i], pi[i], strobe[i]}, 0);
    end
    rst_n = 3'b111;
    repeat (2) @(negedge clk);

    bq = '{8'hA5};       run_burst(0);
    bq = '{8'hFF, 8'h00}; run_burst(0);
    bq = '{8'hC0};       run_burst(1);
    bq = '{8'h5A};       run_burst(2);

    // Reset during data bit 3 of the first byte while a second byte is held.
    bq = '{8'h3C, 8'h96};
    push_burst(0);
    send(0, 8'h3C, 1'b0);
    first_checks(0);
    send(0, 8'h96, 1'b1);
    repeat (27) @(posedge clk);
    @(negedge clk);
    #2;
    abort[0] = 1'b1;
    rst_n[0] = 1'b0;
    #1;
    check("abort_outputs", {busy[0], clk_en[0], pi[0], strobe[0]}, 0);
    check("abort_ready", ready[0], 1);
    @(negedge clk);
    rst_n[0] = 1'b1;
    exp_q[0].delete();
    len_q[0].delete();
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy[0] || strobe[0]) hits++;
    end
    check("quiet_after_reset", hits, 0);

    // Byte accepted during the guard tail starts a new burst after one idle cycle.
    bq = '{8'h81};
    push_burst(0);
    send(0, 8'h81, 1'b1);
    first_checks(0);
    repeat (50) @(posedge clk);
    bq = '{8'h42};
    push_burst(0);
    send(0, 8'h42, 1'b1);
    n = 0;
    while (busy[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    lo = 0;
    while (!busy[0] && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    check("guard_idle_gap", lo, 1);
    wait_idle(0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      repeat (3) begin
        bq.delete();
        repeat ($urandom_range(1, 3)) bq.push_back(8'($urandom));
        run_burst(i);
      end
    end

    for (int i = 0; i < 3; i++) begin
      check("sym_queue_drained", exp_q[i].size(), 0);
      check("len_queue_drained", len_q[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
